// File: rtl/serial_add_if.sv
// serial_add_if: request/result bundle between a requester and the bit-serial adder.
//   start, a, b, cin : request driven by the master, sampled by the adder on accept
//   busy, done       : adder status (busy while bits are processed, done pulse on result)
//   sum, cout, ovf   : registered result, held until the next completion
interface serial_add_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add.sv
// serial_add: bit-serial ripple adder, one add_1 full adder shared across all WIDTH bits.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_if slave (start/a/b/cin in, busy/done/sum/cout/ovf out)
// Optional: define SERIAL_ADD_OVF_EN to register the signed-overflow flag; otherwise ovf is 0.
module add_1 (
   input  logic in_0,
   input  logic in_1,
   input  logic cin,
   output logic out,
   output logic cout
);
   assign out  = in_0 ^ in_1 ^ cin;
   assign cout = (in_0 & in_1) | (cin & (in_0 ^ in_1));
endmodule

module serial_add #(parameter int WIDTH = 8) (
   input logic        clk,
   input logic        rst_n,
   serial_add_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] a_sr, b_sr, sum_r;
   logic [WIDTH-2:0] s_sr;
   logic [CW-1:0]    cnt;
   logic             carry, cout_r, busy_r, done_r, fa_out, fa_cout;
   logic [WIDTH-1:0] s_nxt;
   add_1 u_add (.in_0(a_sr[0]), .in_1(b_sr[0]), .cin(carry), .out(fa_out), .cout(fa_cout));
   // new sum bit enters at the top; after the last bit the whole word is complete
   assign s_nxt = {fa_out, s_sr};
`ifdef SERIAL_ADD_OVF_EN
   logic ovf_r;
   assign bus.ovf = ovf_r;
`else
   assign bus.ovf = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         s_sr   <= '0;
         sum_r  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_r  <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= s_nxt[WIDTH-1:1];
            carry <= fa_cout;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
               sum_r  <= s_nxt;
               cout_r <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
               // carry flop holds the carry into the MSB while the MSB is processed
               ovf_r  <= carry ^ fa_cout;
`endif
               state  <= DONE;
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end else if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            state  <= RUN;
            busy_r <= 1'b1;
         end else begin
            state <= IDLE;
         end
      end
   end
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: randomized self-checking bench for serial_add against an arithmetic model.
module tb_serial_add;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   serial_add_if #(.WIDTH(W)) bus ();
   serial_add #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
`ifdef SERIAL_ADD_OVF_EN
      int s;
      s = int'($signed(a)) + int'($signed(b)) + int'(c);
      return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      check("busy_done_excl", {31'b0, bus.busy & bus.done}, 32'h0);
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      bus.start = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.cin = c;
      tick();
      bus.start = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.cin = 1'($urandom);
      check("busy_on_accept", {31'b0, bus.busy}, 32'h1);
   endtask

   task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int inj);
      logic [W:0] exp;
      int k;
      exp = ref_sum(a, b, c);
      for (k = 1; k <= W + 4; k++) begin
         tick();
         if (bus.done) break;
         check("busy_in_run", {31'b0, bus.busy}, 32'h1);
         bus.start = (k == inj);
         if (k == inj) begin
            bus.a = 8'hAA;
            bus.b = 8'h55;
         end
      end
      bus.start = 1'b0;
      check("latency", k, W);
      check("sum", {24'b0, bus.sum}, {24'b0, exp[W-1:0]});
      check("cout", {31'b0, bus.cout}, {31'b0, exp[W]});
      check("ovf", {31'b0, bus.ovf}, {31'b0, ref_ovf(a, b, c)});
      check("busy_at_done", {31'b0, bus.busy}, 32'h0);
   endtask

   task automatic idle_check();
      tick();
      check("done_pulse_end", {31'b0, bus.done}, 32'h0);
      check("idle_busy", {31'b0, bus.busy}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic rc;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      #1;
      check("rst_sum", {24'b0, bus.sum}, 32'h0);
      check("rst_flags", {28'b0, bus.busy, bus.done, bus.cout, bus.ovf}, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) idle_check();
      launch(8'h0F, 8'h01, 1'b0);
      wait_done(8'h0F, 8'h01, 1'b0, 0);
      idle_check();
      launch(8'hFF, 8'hFF, 1'b1);
      wait_done(8'hFF, 8'hFF, 1'b1, 0);
      idle_check();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_sum", {24'b0, bus.sum}, 32'h0);
      check("async_rst_cout", {31'b0, bus.cout}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      launch(8'hFF, 8'h00, 1'b1);
      wait_done(8'hFF, 8'h00, 1'b1, 0);
      idle_check();
      launch(8'h12, 8'h34, 1'b0);
      wait_done(8'h12, 8'h34, 1'b0, 3);
      repeat (10) idle_check();
      launch(8'h5A, 8'h33, 1'b0);
      wait_done(8'h5A, 8'h33, 1'b0, 0);
      launch(8'h01, 8'h02, 1'b0);
      wait_done(8'h01, 8'h02, 1'b0, 0);
      idle_check();
      launch(8'hC3, 8'h3C, 1'b1);
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      check("midop_rst_busy", {31'b0, bus.busy}, 32'h0);
      check("midop_rst_sum", {24'b0, bus.sum}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) idle_check();
      launch(8'h7F, 8'h01, 1'b0);
      wait_done(8'h7F, 8'h01, 1'b0, 0);
      idle_check();
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         launch(ra, rb, rc);
         wait_done(ra, rb, rc, int'($urandom_range(0, W - 2)));
         if ($urandom_range(0, 1) == 0) idle_check();
      end
      idle_check();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
